// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: clear / skewed-feed / drain sequencer for an output-stationary MAC grid.
// Build option SYSTOLIC_CTRL_PERF_EN adds o_perf_cycles, a saturating count of busy cycles.
module systolic_array_ctrl #(
  parameter int  ARRAY_ROWS = 4,
  parameter int  ARRAY_COLS = 4,
  parameter int  K_W        = 8,
  localparam int RR_W       = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [K_W-1:0]        i_k_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pe_clr_n,
  output logic                  o_op_rd_en,
  output logic [K_W-1:0]        o_op_rd_addr,
  output logic [ARRAY_ROWS-1:0] o_row_feed_en,
  output logic [ARRAY_COLS-1:0] o_col_feed_en,
  output logic                  o_res_valid,
  output logic [RR_W-1:0]       o_res_row,
  input  logic                  i_res_ready
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]           o_perf_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // CLEAR | one-cycle PE accumulator clear
  // RUN   | operand reads and skewed feeds, cnt 0..k_len+ROWS+COLS-2
  // DRAIN | present result rows 0..ROWS-1 under valid/ready
  // DONE  | one-cycle completion pulse

  localparam int              CW         = K_W + 2;
  localparam logic [CW-1:0]   C_SKEW     = CW'(ARRAY_ROWS + ARRAY_COLS - 2);
  localparam logic [RR_W-1:0] C_ROW_LAST = RR_W'(ARRAY_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [K_W-1:0]  r_k_len;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_k_ext;
  logic [CW-1:0]   w_cnt_last;
  logic [RR_W-1:0] r_res_row;
  logic            w_start_ok;
  logic            w_run;
  logic            w_rd_en;

  assign w_k_ext    = {2'b00, r_k_len};
  assign w_cnt_last = w_k_ext + C_SKEW;
  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign w_run      = (r_state == S_RUN);
  assign w_rd_en    = w_run && (r_cnt < w_k_ext);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_DONE);
    o_pe_clr_n    = (r_state != S_CLEAR);
    o_op_rd_en    = w_rd_en;
    o_op_rd_addr  = w_rd_en ? r_cnt[K_W-1:0] : '0;
    o_res_valid   = (r_state == S_DRAIN);
    o_res_row     = r_res_row;
    o_row_feed_en = '0;
    o_col_feed_en = '0;

    // Feed lags the read by one cycle (buffer latency), plus one cycle per row/column of skew.
    for (int i = 0; i < ARRAY_ROWS; i++)
      o_row_feed_en[i] = w_run && (r_cnt >= CW'(i + 1)) && (r_cnt < w_k_ext + CW'(i + 1));
    for (int j = 0; j < ARRAY_COLS; j++)
      o_col_feed_en[j] = w_run && (r_cnt >= CW'(j + 1)) && (r_cnt < w_k_ext + CW'(j + 1));

    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = (r_k_len != '0) ? S_RUN : S_DRAIN;
      S_RUN:   if (r_cnt == w_cnt_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (i_res_ready && (r_res_row == C_ROW_LAST)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_k_len   <= '0;
      r_cnt     <= '0;
      r_res_row <= '0;
    end else begin
      if (w_start_ok) r_k_len <= i_k_len;

      if (w_run && (r_cnt != w_cnt_last)) r_cnt <= r_cnt + 1'b1;
      else                                r_cnt <= '0;

      if (r_state == S_DRAIN) begin
        if (i_res_ready)
          r_res_row <= (r_res_row == C_ROW_LAST) ? '0 : r_res_row + 1'b1;
      end else begin
        r_res_row <= '0;
      end
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge i_clk) begin
    if (!i_rstn)                                         r_perf <= '0;
    else if (w_start_ok)                                 r_perf <= '0;
    else if ((r_state != S_IDLE) && (r_perf != '1))      r_perf <= r_perf + 1'b1;
  end

  assign o_perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl (4x4, K_W=8); define SYSTOLIC_CTRL_PERF_EN to also cover o_perf_cycles.
`timescale 1ns/1ps
module tb_systolic_array_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [7:0] k_len;
  logic       res_ready;
  logic       busy, done, pe_clr_n, op_rd_en, res_valid;
  logic [7:0] op_rd_addr;
  logic [3:0] row_feed_en, col_feed_en;
  logic [1:0] res_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  systolic_array_ctrl #(.ARRAY_ROWS(4), .ARRAY_COLS(4), .K_W(8)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_start       (start),
    .i_k_len       (k_len),
    .o_busy        (busy),
    .o_done        (done),
    .o_pe_clr_n    (pe_clr_n),
    .o_op_rd_en    (op_rd_en),
    .o_op_rd_addr  (op_rd_addr),
    .o_row_feed_en (row_feed_en),
    .o_col_feed_en (col_feed_en),
    .o_res_valid   (res_valid),
    .o_res_row     (res_row),
    .i_res_ready   (res_ready)
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    .o_perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // {busy, done, pe_clr_n, op_rd_en, op_rd_addr, row_feed_en, col_feed_en, res_valid, res_row}
  logic [22:0] obs;
  assign obs = {busy, done, pe_clr_n, op_rd_en, op_rd_addr, row_feed_en, col_feed_en, res_valid, res_row};

  function automatic logic [22:0] ex(input logic b, input logic d, input logic c, input logic r,
                                     input logic [7:0] a, input logic [3:0] rf, input logic [3:0] cf,
                                     input logic v, input logic [1:0] rr);
    return {b, d, c, r, a, rf, cf, v, rr};
  endfunction

  // Feed-enable pattern for k_len=3, indexed by RUN count 0..9.
  logic [3:0] feed_k3 [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110,
                               4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};

  logic [22:0] idle_v;
  logic [22:0] e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; k_len = 8'd5; res_ready = 1'b1;
    tick(); tick();
    n_vec++;
    if (obs !== idle_v) begin
      n_err++; $display("FAIL reset_outputs got=%h expected=%h", obs, idle_v);
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    n_vec++;
    if (perf_cycles !== 32'd0) begin
      n_err++; $display("FAIL reset_perf got=%0d expected=0", perf_cycles);
    end
`endif
    start = 1'b0; rstn = 1'b1;
    tick();
    n_vec++;
    if (obs !== idle_v) begin
      n_err++; $display("FAIL idle_after_reset got=%h expected=%h", obs, idle_v);
    end
  endtask

  task automatic test_basic();
    int bc;
    res_ready = 1'b1; k_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0; k_len = 8'd0;
    bc = 0;
    e = ex(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++; if (busy) bc++;
    if (obs !== e) begin n_err++; $display("FAIL basic_clear got=%h expected=%h", obs, e); end
    tick();
    for (int c = 0; c < 10; c++) begin
      e = ex(1, 0, 1, (c < 3), (c < 3) ? 8'(c) : 8'd0, feed_k3[c], feed_k3[c], 0, 2'd0);
      n_vec++; if (busy) bc++;
      if (obs !== e) begin n_err++; $display("FAIL basic_run cnt=%0d got=%h expected=%h", c, obs, e); end
      tick();
    end
    for (int r = 0; r < 4; r++) begin
      e = ex(1, 0, 1, 0, 8'd0, 4'h0, 4'h0, 1, 2'(r));
      n_vec++; if (busy) bc++;
      if (obs !== e) begin n_err++; $display("FAIL basic_drain row=%0d got=%h expected=%h", r, obs, e); end
      tick();
    end
    e = ex(1, 1, 1, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++; if (busy) bc++;
    if (obs !== e) begin n_err++; $display("FAIL basic_done got=%h expected=%h", obs, e); end
    tick();
    n_vec++;
    if (obs !== idle_v) begin n_err++; $display("FAIL basic_idle got=%h expected=%h", obs, idle_v); end
    n_vec++;
    if (bc != 16) begin n_err++; $display("FAIL basic_busy_cycles got=%0d expected=16", bc); end
  endtask

  task automatic test_k_zero();
    res_ready = 1'b1; k_len = 8'd0; start = 1'b1;
    tick(); start = 1'b0;
    e = ex(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL kzero_clear got=%h expected=%h", obs, e); end
    tick();
    for (int r = 0; r < 4; r++) begin
      e = ex(1, 0, 1, 0, 8'd0, 4'h0, 4'h0, 1, 2'(r));
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL kzero_drain row=%0d got=%h expected=%h", r, obs, e); end
      tick();
    end
    e = ex(1, 1, 1, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL kzero_done got=%h expected=%h", obs, e); end
    tick();
    n_vec++;
    if (obs !== idle_v) begin n_err++; $display("FAIL kzero_idle got=%h expected=%h", obs, idle_v); end
  endtask

  task automatic test_backpressure();
    bit seen;
    res_ready = 1'b1; k_len = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      if (res_valid) begin seen = 1; break; end
      tick();
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL bp_wait_valid got=timeout expected=res_valid"); end
    tick(); tick();
    e = ex(1, 0, 1, 0, 8'd0, 4'h0, 4'h0, 1, 2'd2);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bp_row2 got=%h expected=%h", obs, e); end
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_vec++;
      if (obs !== e) begin n_err++; $display("FAIL bp_stall cyc=%0d got=%h expected=%h", s, obs, e); end
    end
    res_ready = 1'b1;
    tick();
    e = ex(1, 0, 1, 0, 8'd0, 4'h0, 4'h0, 1, 2'd3);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bp_row3 got=%h expected=%h", obs, e); end
    tick();
    e = ex(1, 1, 1, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL bp_done got=%h expected=%h", obs, e); end
    tick();
  endtask

  task automatic test_start_ignored();
    int dc, bc;
    res_ready = 1'b1; k_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0; k_len = 8'd9;
    dc = 0; bc = 0;
    for (int n = 0; n < 40; n++) begin
      start = (n == 4);
      if (done) begin dc++; start = 1'b1; end
      if (busy) bc++;
      tick();
    end
    start = 1'b0;
    n_vec++;
    if (dc != 1) begin n_err++; $display("FAIL ign_done_pulses got=%0d expected=1", dc); end
    n_vec++;
    if (bc != 16) begin n_err++; $display("FAIL ign_busy_cycles got=%0d expected=16", bc); end
    n_vec++;
    if (obs !== idle_v) begin n_err++; $display("FAIL ign_idle got=%h expected=%h", obs, idle_v); end
  endtask

  task automatic test_mid_reset();
    int bc;
    bit seen;
    res_ready = 1'b1; k_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    rstn = 1'b0;
    tick();
    n_vec++;
    if (obs !== idle_v) begin n_err++; $display("FAIL midrst_outputs got=%h expected=%h", obs, idle_v); end
    rstn = 1'b1; k_len = 8'd1; start = 1'b1;
    tick(); start = 1'b0;
    e = ex(1, 0, 0, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL midrst_clear got=%h expected=%h", obs, e); end
    tick();
    e = ex(1, 0, 1, 1, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL midrst_run0 got=%h expected=%h", obs, e); end
    tick();
    e = ex(1, 0, 1, 0, 8'd0, 4'h1, 4'h1, 0, 2'd0);
    n_vec++;
    if (obs !== e) begin n_err++; $display("FAIL midrst_run1 got=%h expected=%h", obs, e); end
    bc = 3; seen = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (busy) bc++;
      if (done) begin seen = 1; break; end
    end
    n_vec++;
    if (!seen || bc != 14) begin
      n_err++; $display("FAIL midrst_second_op got=busy%0d/done%0d expected=busy14/done1", bc, seen);
    end
    tick();
  endtask

  task automatic test_k_max();
    int bc, rc;
    bit seen, seq_ok;
    logic [7:0] max_a, exp_a;
    res_ready = 1'b1; k_len = 8'd255; start = 1'b1;
    tick(); start = 1'b0;
    bc = 0; rc = 0; seen = 0; seq_ok = 1; max_a = 8'd0; exp_a = 8'd0;
    for (int n = 0; n < 400; n++) begin
      if (busy) bc++;
      if (op_rd_en) begin
        rc++;
        if (op_rd_addr != exp_a) seq_ok = 0;
        if (op_rd_addr > max_a) max_a = op_rd_addr;
        exp_a = exp_a + 8'd1;
      end
      if (done) begin seen = 1; break; end
      tick();
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL kmax_done got=timeout expected=done"); end
    n_vec++;
    if (bc != 268) begin n_err++; $display("FAIL kmax_busy_cycles got=%0d expected=268", bc); end
    n_vec++;
    if (rc != 255 || max_a != 8'd254 || !seq_ok) begin
      n_err++; $display("FAIL kmax_reads got=%0d/max%0d/seq%0d expected=255/max254/seq1", rc, max_a, seq_ok);
    end
    tick();
  endtask

`ifdef SYSTOLIC_CTRL_PERF_EN
  task automatic test_perf();
    bit seen;
    res_ready = 1'b1; k_len = 8'd3; start = 1'b1;
    tick(); start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) begin seen = 1; break; end
      tick();
    end
    tick();
    n_vec++;
    if (!seen || perf_cycles !== 32'd16) begin
      n_err++; $display("FAIL perf_after_done got=%0d expected=16", perf_cycles);
    end
    tick(); tick(); tick();
    n_vec++;
    if (perf_cycles !== 32'd16) begin n_err++; $display("FAIL perf_hold got=%0d expected=16", perf_cycles); end
    k_len = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    n_vec++;
    if (perf_cycles !== 32'd0) begin n_err++; $display("FAIL perf_zero_on_start got=%0d expected=0", perf_cycles); end
    tick();
    n_vec++;
    if (perf_cycles !== 32'd1) begin n_err++; $display("FAIL perf_count got=%0d expected=1", perf_cycles); end
    for (int n = 0; n < 40; n++) begin
      if (!busy) break;
      tick();
    end
  endtask
`endif

  initial begin
    idle_v = ex(0, 0, 1, 0, 8'd0, 4'h0, 4'h0, 0, 2'd0);
    rstn = 1'b0; start = 1'b0; k_len = 8'd0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_k_zero();
    test_backpressure();
    test_start_ignored();
    test_mid_reset();
    test_k_max();
`ifdef SYSTOLIC_CTRL_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
